// File: rtl/mem_port_ctrl_pkg.sv
// Shared types and constants for the unified memory port controller.
package mem_port_ctrl_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned CNT_W_DEF = 16;

  // add x0,x0,x0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0033;

  typedef enum logic [1:0] {
    S_DPRI = 2'd0,
    S_FPRI = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/mem_port_ctrl_align.sv
// Natural-alignment check for a data access from funct3 and the low address bits.
module align_check
  import mem_port_ctrl_pkg::*;
(
  input  logic [2:0] func3,
  input  logic [1:0] addr_lo,
  output logic       mis
);

  // Store funct3 codes share encodings with the loads, so one decode covers both.
  always_comb begin
    mis = 1'b0;
    case (func3)
      F3_LH, F3_LHU: mis = addr_lo[0];
      F3_LW:         mis = |addr_lo;
      default:       mis = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_port_ctrl.sv
// Arbitrates the single memory port between instruction fetch and data access,
// registers fetch/load results, traps misaligned data accesses and counts stalls.
module mem_port_ctrl
  import mem_port_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN  = XLEN_DEF,
  parameter int unsigned     CNT_W = CNT_W_DEF,
  parameter logic [XLEN-1:0] NOP   = XLEN'(NOP_INSTR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [XLEN-1:0]  if_addr,
  input  logic             dm_read,
  input  logic             dm_write,
  input  logic [2:0]       dm_func3,
  input  logic [XLEN-1:0]  dm_addr,
  input  logic [XLEN-1:0]  dm_wdata,
  input  logic             err_ack,
  output logic             mem_using,
  output logic             mem_read,
  output logic             mem_write,
  output logic [2:0]       mem_func3,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             if_stall,
  output logic             dm_stall,
  output logic [XLEN-1:0]  instr,
  output logic             instr_valid,
  output logic [XLEN-1:0]  load_data,
  output logic             load_valid,
  output logic             err,
  output logic [XLEN-1:0]  err_addr,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t state, state_cur, state_next;
  logic   dm_req, mis_raw, mis, dgnt, fgnt;

  assign dm_req = dm_read | dm_write;

  align_check u_align (
    .func3   (dm_func3),
    .addr_lo (dm_addr[1:0]),
    .mis     (mis_raw)
  );

  assign mis = dm_req & mis_raw;

  // Combinational paths see the reset state while rst is asserted.
  assign state_cur = rst ? S_DPRI : state;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_DPRI;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_cur;
    case (state_cur)
      S_DPRI: begin
        if (mis)                 state_next = S_HOLD;
        else if (dgnt && if_req) state_next = S_FPRI;
      end
      S_FPRI: begin
        if (mis)       state_next = S_HOLD;
        else if (fgnt) state_next = S_DPRI;
      end
      S_HOLD: begin
        if (err_ack) state_next = S_DPRI;
      end
      default: state_next = S_DPRI;
    endcase
  end

  // Grants, port drive and stalls
  always_comb begin
    dgnt      = 1'b0;
    fgnt      = 1'b0;
    mem_using = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_func3 = 3'b000;
    mem_addr  = '0;
    mem_wdata = '0;

    dgnt = dm_req && !mis &&
           ((state_cur == S_DPRI) || ((state_cur == S_FPRI) && !if_req));
    fgnt = if_req && !dgnt && (state_cur != S_HOLD);

    if (dgnt) begin
      mem_using = 1'b1;
      mem_read  = dm_read;
      mem_write = dm_write;
      mem_func3 = dm_func3;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (fgnt) begin
      mem_using = 1'b1;
      mem_func3 = F3_LW;
      mem_addr  = if_addr;
    end

    if_stall = if_req & ~fgnt;
    dm_stall = dm_req & ~dgnt;
  end

  // Registered results, trap capture and stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      instr       <= NOP;
      instr_valid <= 1'b0;
      load_data   <= '0;
      load_valid  <= 1'b0;
      err         <= 1'b0;
      err_addr    <= '0;
      stall_cnt   <= '0;
    end else begin
      instr_valid <= fgnt;
      load_valid  <= dgnt & dm_read;
      if (fgnt)            instr     <= mem_rdata;
      if (dgnt && dm_read) load_data <= mem_rdata;

      if ((state != S_HOLD) && (state_next == S_HOLD)) begin
        err      <= 1'b1;
        err_addr <= dm_addr;
      end else if ((state == S_HOLD) && err_ack) begin
        err <= 1'b0;
      end

      if ((if_stall || dm_stall) && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
